shift_sub_divider: RTL and testbench

Sequential unsigned restoring divider, the inverse of the team's 32-bit shift-add multiplier `mult`. It takes a dividend and divisor on a start strobe and computes one quotient bit per clock. It returns quotient and remainder with a one-cycle done pulse. It sits beside `mult` in the arithmetic datapath and lets a `mult` product be checked by division.

---
 rtl/shift_sub_divider_if.sv | 23 ++
 rtl/shift_sub_divider.sv | 121 ++++++++++++
 tb/tb_shift_sub_divider.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/shift_sub_divider_if.sv
// rtl/shift_sub_divider_if.sv - request/result bundle for the restoring divider
interface shift_sub_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  q, r, busy, done, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, div_by_zero
    );
endinterface

// File: rtl/shift_sub_divider.sv
// rtl/shift_sub_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module shift_sub_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    shift_sub_divider_if.slave div
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_dbz;
    logic             w_busy;
    logic             w_done;

    // The restored remainder is always below the divisor, so only the shifted
    // value and the trial difference need the extra bit.
    logic [WIDTH:0]   w_shift_rem;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_div};
    assign w_ge        = ~w_trial[WIDTH];
    assign w_rem_nxt   = w_ge ? w_trial[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
    assign w_quo_nxt   = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (div.start) begin
                    w_next = (div.b != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_div <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_dbz <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div.start) begin
                        if (div.b != '0) begin
                            r_quo <= div.a;
                            r_div <= div.b;
                            r_rem <= '0;
                            r_cnt <= CW'(WIDTH - 1);
                        end else begin
                            r_q   <= '1;
                            r_r   <= div.a;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    // Results are published only on the final step so q/r stay steady during a run.
                    if (r_cnt == '0) begin
                        r_q   <= w_quo_nxt;
                        r_r   <= w_rem_nxt;
                        r_dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign div.q           = r_q;
    assign div.r           = r_r;
    assign div.div_by_zero = r_dbz;
    assign div.busy        = w_busy;
    assign div.done        = w_done;
endmodule

// File: tb/tb_shift_sub_divider.sv
// tb/tb_shift_sub_divider.sv - directed and randomized checks of shift_sub_divider
module tb_shift_sub_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_miscmp = 0;

    always #5 clk = ~clk;

    shift_sub_divider_if #(.WIDTH(W)) dif ();

    shift_sub_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .div (dif)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; the start is sampled at the next rising edge (E).
    // Returns at the falling edge just after E.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        dif.a     = a;
        dif.b     = b;
        dif.start = 1'b1;
        @(negedge clk);
        dif.start = 1'b0;
    endtask

    // k counts rising edges since E; lat is the k at which done is seen, -1 on timeout.
    task automatic wait_done(input int k0, output int lat, output int busy_cycles);
        lat = -1;
        busy_cycles = 0;
        for (int k = k0; k <= k0 + 40; k++) begin
            if (dif.done) begin
                lat = k;
                break;
            end
            if (dif.busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int             lat;
        int             bc;
        logic [W-1:0]   eq;
        logic [W-1:0]   er;
        logic [W-1:0]   hq;
        logic [W-1:0]   hr;
        if (b == '0) begin
            eq = '1;
            er = a;
        end else begin
            eq = a / b;
            er = a % b;
        end
        start_op(a, b);
        wait_done(0, lat, bc);
        if (b == '0) begin
            check({tag, "_lat"}, 64'((lat >= 0) && (lat <= 1)), 64'd1);
        end else begin
            check({tag, "_lat"}, 64'(lat), 64'(W));
        end
        check({tag, "_busy"}, 64'(bc), (b == '0) ? 64'd0 : 64'(W));
        check({tag, "_q"}, 64'(dif.q), 64'(eq));
        check({tag, "_r"}, 64'(dif.r), 64'(er));
        check({tag, "_dbz"}, 64'(dif.div_by_zero), 64'(b == '0));
        check({tag, "_excl"}, 64'(dif.done & dif.busy), 64'd0);
        hq = dif.q;
        hr = dif.r;
        @(negedge clk);
        check({tag, "_pulse"}, 64'(dif.done), 64'd0);
        check({tag, "_hold"}, {dif.q, dif.r}, {hq, hr});
    endtask

    initial begin
        int lat;
        int bc;
        int n_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_q", 64'(dif.q), 64'd0);
        check("rst_r", 64'(dif.r), 64'd0);
        check("rst_busy", 64'(dif.busy), 64'd0);
        check("rst_done", 64'(dif.done), 64'd0);
        check("rst_dbz", 64'(dif.div_by_zero), 64'd0);

        run_div("d100_7", 32'd100, 32'd7);
        run_div("max_1", 32'hFFFF_FFFF, 32'd1);
        run_div("max_msb", 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("7_max", 32'd7, 32'hFFFF_FFFF);
        run_div("0_5", 32'd0, 32'd5);
        run_div("dbz5", 32'd5, 32'd0);
        run_div("d9_3", 32'd9, 32'd3);

        // A start pulse in the middle of a run must not disturb it.
        start_op(32'd50, 32'd5);
        repeat (9) @(negedge clk);
        start_op(32'd1, 32'd1);
        wait_done(10, lat, bc);
        check("ign_lat", 64'(lat), 64'(W));
        check("ign_q", 64'(dif.q), 64'd10);
        check("ign_r", 64'(dif.r), 64'd0);
        @(negedge clk);

        // Reset in the middle of a run aborts it without a done.
        start_op(32'd100, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_q", 64'(dif.q), 64'd0);
        check("abort_r", 64'(dif.r), 64'd0);
        check("abort_busy", 64'(dif.busy), 64'd0);
        check("abort_done", 64'(dif.done), 64'd0);
        check("abort_dbz", 64'(dif.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        bc = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.done) n_done++;
            if (dif.busy) bc++;
        end
        check("abort_nodone", 64'(n_done), 64'd0);
        check("abort_nobusy", 64'(bc), 64'd0);
        run_div("d100_3", 32'd100, 32'd3);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(3) == 0) rb = rb >> $urandom_range(31);
            if (rb == '0 || $urandom_range(99) == 0) rb = '0;
            run_div("rnd", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
